// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter
//   Arbitrates the single FP register-file write port between the FP load
//   path (FLW results, no back-pressure) and the FPU result path
//   (valid/ready handshake). It writes one result per cycle, with priority
//   load > buffered FPU result > FPU result accepted this cycle.
//   FPU results that cannot be written at once wait in a small in-order FIFO.
//   The write port is registered.
//
//   Optional build macro FP_WB_SCOREBOARD_EN enables a per-register
//   pending-write scoreboard on busy_o. Without the macro, busy_o is
//   tied to zero.
//
// Parameters
//   FIFO_DEPTH  number of buffered FPU results (power of two, >= 2)
// Ports
//   clk_i                     rising-edge clock
//   rst_ni                    synchronous active-low reset
//   ld_valid_i/ld_rd_i/ld_data_i           load result (always accepted)
//   fpu_valid_i/fpu_ready_o/fpu_rd_i/fpu_data_i  FPU result handshake
//   iss_valid_i/iss_rd_i      FP-writing instruction issued (scoreboard set)
//   wb_en_o/rd_index_o/rd_data_o           registered register-file write port
//   busy_o                    per-register pending-write flags
module fp_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ld_valid_i,
  input  logic [4:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [4:0]  fpu_rd_i,
  input  logic [31:0] fpu_data_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  output logic        wb_en_o,
  output logic [4:0]  rd_index_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [4:0]       fifo_rd_r   [FIFO_DEPTH];
  logic [31:0]      fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             wb_en_r;
  logic [4:0]       rd_index_r;
  logic [31:0]      rd_data_r;

  logic             accept_s;
  logic             sel_s;
  logic [4:0]       sel_rd_s;
  logic [31:0]      sel_data_s;
  logic             enq_s;
  logic             deq_s;

  // Ready comes from the registered count only. A dequeue in the same cycle
  // does not raise it, so there is no combinational path from the load inputs.
  assign fpu_ready_o = rst_ni & (count_r < DEPTH_C);
  assign accept_s    = fpu_valid_i & fpu_ready_o;

  // Write-source selection and FIFO enqueue/dequeue decisions
  always_comb begin
    sel_s      = 1'b0;
    sel_rd_s   = rd_index_r;
    sel_data_s = rd_data_r;
    enq_s      = 1'b0;
    deq_s      = 1'b0;
    if (ld_valid_i) begin
      // Load wins; any FPU result accepted this cycle must wait in the FIFO.
      sel_s      = 1'b1;
      sel_rd_s   = ld_rd_i;
      sel_data_s = ld_data_i;
      enq_s      = accept_s;
    end else if (count_r != {CNT_W{1'b0}}) begin
      // Oldest buffered FPU result goes first, which keeps FPU order.
      sel_s      = 1'b1;
      sel_rd_s   = fifo_rd_r[rd_ptr_r];
      sel_data_s = fifo_data_r[rd_ptr_r];
      deq_s      = 1'b1;
      enq_s      = accept_s;
    end else if (accept_s) begin
      // Empty FIFO and no load: bypass straight to the output register.
      sel_s      = 1'b1;
      sel_rd_s   = fpu_rd_i;
      sel_data_s = fpu_data_i;
    end else begin
      sel_s      = 1'b0;
    end
  end

  // Output register, FIFO pointers and occupancy count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_en_r    <= 1'b0;
      rd_index_r <= 5'd0;
      rd_data_r  <= 32'd0;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
    end else begin
      wb_en_r    <= sel_s;
      rd_index_r <= sel_rd_s;
      rd_data_r  <= sel_data_s;
      // Power-of-two depth, so pointer increments wrap modulo FIFO_DEPTH.
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

  // FIFO storage; contents are don't-care while the count is zero
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      fifo_rd_r[wr_ptr_r]   <= fpu_rd_i;
      fifo_data_r[wr_ptr_r] <= fpu_data_i;
    end
  end

  assign wb_en_o    = wb_en_r;
  assign rd_index_o = rd_index_r;
  assign rd_data_o  = rd_data_r;

`ifdef FP_WB_SCOREBOARD_EN
  logic [31:0] busy_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;

  // Set/clear masks: set on issue, clear on the edge where the write is presented
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (iss_valid_i) begin
      set_mask_s = 32'd1 << iss_rd_i;
    end else begin
      set_mask_s = 32'd0;
    end
    if (wb_en_r) begin
      clr_mask_s = 32'd1 << rd_index_r;
    end else begin
      clr_mask_s = 32'd0;
    end
  end

  // Busy flags; the set is ORed in after the clear, so a set wins on the same index
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign busy_o = busy_r;
`else
  logic unused_iss_s;
  assign unused_iss_s = ^{iss_valid_i, iss_rd_i};
  assign busy_o       = 32'd0;
`endif

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 2, number of buffered FPU results (power of two, minimum 2).
REQ-002 SHALL provide ports clk_i, in, 1, rising-edge clock for all state.
REQ-003 SHALL provide rst_ni, in, 1; reset is synchronous and active-low.
REQ-004 SHALL provide ld_valid_i, in, 1, FP load (FLW) result valid; ld_rd_i, in, 5, destination; ld_data_i, in, 32, data.
REQ-005 SHALL provide fpu_valid_i, in, 1; fpu_ready_o, out, 1; fpu_rd_i, in, 5; fpu_data_i, in, 32: FPU result handshake.
REQ-006 SHALL provide iss_valid_i, in, 1, FP-writing instruction issued; iss_rd_i, in, 5, its destination.
REQ-007 SHALL provide wb_en_o, out, 1; rd_index_o, out, 5; rd_data_o, out, 32: the single FP register-file write port.
REQ-008 SHALL provide busy_o, out, 32, per-register pending-write bits.

Function
REQ-009 SHALL accept a load result every cycle ld_valid_i=1; the load port has no back-pressure.
REQ-010 SHALL transfer an FPU result in a cycle where fpu_valid_i=1 and fpu_ready_o=1.
REQ-011 SHALL drive fpu_ready_o = 1 exactly when the FIFO count is below FIFO_DEPTH (registered count; a same-cycle dequeue does not raise ready).
REQ-012 SHALL select one write per cycle with priority: load > FIFO head > FPU result accepted this cycle.
REQ-013 SHALL send an accepted FPU result straight to the output register when no load is valid and the FIFO is empty; otherwise it SHALL enqueue it.
REQ-014 SHALL dequeue the FIFO head in any cycle with no valid load, with simultaneous enqueue allowed.
REQ-015 SHALL register wb_en_o/rd_index_o/rd_data_o: a selected result appears one cycle after acceptance; wb_en_o=0 with index/data held when nothing is selected.
REQ-016 SHALL preserve FPU result order; loads may overtake buffered FPU results.
REQ-017 SHALL treat f0 as an ordinary writable register (no x0-style masking).
REQ-018 SHALL set busy_o[iss_rd_i] on the clock edge where iss_valid_i=1.
REQ-019 SHALL clear busy_o[rd_index_o] on the clock edge where wb_en_o=1.
REQ-020 SHALL give set priority over clear when both target the same index in the same cycle.
REQ-021 SHALL keep busy bits as single flags (no counting); issue logic stalls on busy rd, and the block does not detect violations.
REQ-022 SHALL never drop or duplicate a result; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-023 SHALL, while rst_ni=0 at a clock edge, clear wb_en_o, rd_index_o, rd_data_o, busy_o and the FIFO count/pointers to 0.
REQ-024 SHALL force fpu_ready_o=0 while rst_ni=0 and 1 in the first cycle after release.
REQ-025 SHALL discard buffered or in-flight results when reset is asserted mid-operation; no write is issued for them.

Configuration
REQ-026 SHALL, with FP_WB_SCOREBOARD_EN defined, implement busy tracking per REQ-018..REQ-021.
REQ-027 SHALL, without FP_WB_SCOREBOARD_EN, tie busy_o to 0, ignore iss_valid_i/iss_rd_i, and implement no busy flops; write-port behaviour is unchanged.

Verification
REQ-028 Bench SHALL cover: FPU f3=0x3F800000 alone, FIFO empty -> next cycle wb_en_o=1, rd_index_o=3, rd_data_o=0x3F800000.
REQ-029 Bench SHALL cover: load f1=0x11111111 and FPU f2=0x22222222 same cycle -> f1 written cycle+1, f2 cycle+2.
REQ-030 Bench SHALL cover: loads every cycle for 4 cycles while FPU offers f4,f5,f6 -> f4,f5 accepted, fpu_ready_o=0 while full, f4,f5,f6 written in order after loads stop.
REQ-031 Bench SHALL cover (scoreboard on): issue rd=7, then write f7 -> busy_o[7] 1 until the edge with wb_en_o=1/rd_index_o=7, then 0; issue rd=7 coincident with that write -> busy_o[7] stays 1.
REQ-032 Bench SHALL cover: rst_ni=0 with 2 FIFO entries and busy_o=0x00000088 -> all outputs 0, no write after release, fpu_ready_o=1.
REQ-033 Bench SHALL cover (scoreboard off): iss_valid_i pulses rd=9 -> busy_o stays 0x00000000.
